// File: rtl/mc_control_hs.sv
// Multicycle control unit for the RISC-V multicycle CPU.
// Steps each instruction through IF/ID/EX/MEM/WB states with a memory-ready
// handshake, sends illegal encodings to a sticky TRAP state, and keeps
// cycle and retired-instruction counters.
// Ports:
//   CLK, RSTn            clock, synchronous active-low reset
//   opcode, funct3       instruction fields from IR
//   MEM_READY            memory completes the current access this cycle
//   RegDst..PCWrite      datapath control strobes (combinational)
//   ALUOp                mirrors opcode
//   BE                   byte enable for loads/stores
//   Concat_control       immediate-format select
//   Halt                 high in TRAP
//   state_o              current state encoding
//   cycle_cnt            cycles since reset
//   retire_cnt           instructions retired since reset
module mc_control_hs #(
  parameter int unsigned CNT_W         = 32,
  parameter bit          MEM_HANDSHAKE = 1'b1
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             MEM_READY,
  output logic             RegDst,
  output logic             Jump,
  output logic             Branch,
  output logic             MemRead,
  output logic             MemtoReg,
  output logic             MemWrite,
  output logic             ALUSrc1,
  output logic             ALUSrc2,
  output logic             RegWrite,
  output logic             JALorJALR,
  output logic             PCWrite,
  output logic [6:0]       ALUOp,
  output logic [3:0]       BE,
  output logic [2:0]       Concat_control,
  output logic             Halt,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_IF     = 4'd0,  S_ID   = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR = 4'd5, S_REX    = 4'd6,  S_ALUWB = 4'd7,
    S_BR     = 4'd8,  S_JAL  = 4'd9,  S_JALR   = 4'd10, S_JWB   = 4'd11,
    S_IEX    = 4'd12, S_UEX  = 4'd13, S_UWB    = 4'd14, S_TRAP  = 4'd15
  } state_t;

  state_t state;
  state_t state_next;
  logic   mem_rdy_c;
  logic   retire_c;

  // Without the handshake, memory is assumed to finish every access at once.
  assign mem_rdy_c = MEM_HANDSHAKE ? MEM_READY : 1'b1;

  assign retire_c = (state_next == S_IF) &&
                    (state inside {S_MEMWB, S_MEMWR, S_ALUWB, S_BR, S_JWB, S_UWB});

  assign state_o = state;

  // State register
  always_ff @(posedge CLK) begin
    if (!RSTn) state <= S_IF;
    else       state <= state_next;
  end

  // Next-state logic, including illegal-encoding detection in ID
  always_comb begin
    state_next = state;
    case (state)
      S_IF:     if (mem_rdy_c) state_next = S_ID;
      S_ID: begin
        case (opcode)
          OP_LOAD:  state_next = (funct3 == 3'b011 || funct3 == 3'b110 ||
                                  funct3 == 3'b111) ? S_TRAP : S_MEMADR;
          OP_STORE: state_next = (funct3 > 3'b010) ? S_TRAP : S_MEMADR;
          OP_R:     state_next = S_REX;
          OP_BR:    state_next = (funct3 == 3'b010 || funct3 == 3'b011) ? S_TRAP : S_BR;
          OP_JAL:   state_next = S_JAL;
          OP_JALR:  state_next = (funct3 != 3'b000) ? S_TRAP : S_JALR;
          OP_I:     state_next = S_IEX;
          OP_LUI,
          OP_AUIPC: state_next = S_UEX;
          default:  state_next = S_TRAP;
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy_c) state_next = S_MEMWB;
      S_MEMWR:  if (mem_rdy_c) state_next = S_IF;
      S_MEMWB:  state_next = S_IF;
      S_REX:    state_next = S_ALUWB;
      S_IEX:    state_next = S_ALUWB;
      S_ALUWB:  state_next = S_IF;
      S_BR:     state_next = S_IF;
      S_JAL:    state_next = S_JWB;
      S_JALR:   state_next = S_JWB;
      S_JWB:    state_next = S_IF;
      S_UEX:    state_next = S_UWB;
      S_UWB:    state_next = S_IF;
      S_TRAP:   state_next = S_TRAP;
      default:  state_next = S_TRAP;
    endcase
  end

  // Output decode; every output is defined in every state
  always_comb begin
    RegDst         = 1'b0;
    Jump           = 1'b0;
    Branch         = 1'b0;
    MemRead        = 1'b0;
    MemtoReg       = 1'b0;
    MemWrite       = 1'b0;
    ALUSrc1        = 1'b0;
    ALUSrc2        = 1'b0;
    RegWrite       = 1'b0;
    JALorJALR      = 1'b0;
    PCWrite        = 1'b0;
    ALUOp          = opcode;
    BE             = 4'b0000;
    Concat_control = 3'b000;
    Halt           = 1'b0;
    case (state)
      S_IF: begin
        MemRead = 1'b1;
        PCWrite = mem_rdy_c;
      end
      S_MEMADR: begin
        ALUSrc2        = 1'b1;
        Concat_control = (opcode == OP_LOAD) ? 3'b011 : 3'b101;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        case (funct3)
          3'b000, 3'b100: BE = 4'b0001;
          3'b001, 3'b101: BE = 4'b0011;
          3'b010:         BE = 4'b1111;
          default:        BE = 4'b0000;
        endcase
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        case (funct3)
          3'b000:  BE = 4'b0001;
          3'b001:  BE = 4'b0011;
          3'b010:  BE = 4'b1111;
          default: BE = 4'b0000;
        endcase
      end
      S_MEMWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_IEX: begin
        ALUSrc2        = 1'b1;
        Concat_control = (funct3 == 3'b001 || funct3 == 3'b101) ? 3'b110 : 3'b011;
      end
      S_ALUWB, S_UWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BR: begin
        Branch         = 1'b1;
        Concat_control = 3'b100;
      end
      S_JAL: begin
        ALUSrc1        = 1'b1;
        ALUSrc2        = 1'b1;
        Jump           = 1'b1;
        Concat_control = 3'b010;
      end
      S_JALR: begin
        ALUSrc2        = 1'b1;
        Jump           = 1'b1;
        JALorJALR      = 1'b1;
        Concat_control = 3'b011;
      end
      S_JWB: begin
        Jump      = 1'b1;
        RegDst    = 1'b1;
        RegWrite  = 1'b1;
        JALorJALR = (opcode == OP_JALR);
      end
      S_UEX: begin
        ALUSrc1        = 1'b1;
        ALUSrc2        = 1'b1;
        Concat_control = 3'b001;
      end
      S_TRAP:  Halt = 1'b1;
      default: ;
    endcase
    // An instruction cut short by reset must not write anything.
    if (!RSTn) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

  // Cycle and retired-instruction counters, each wrapping independently
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (retire_c) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_hs.sv
// Testbench for mc_control_hs: directed vector table plus hand-written
// sequences for wait states, traps, no-handshake mode, reset abort and
// counter wrap. A second instance uses MEM_HANDSHAKE=0 and 4-bit counters.
module tb_mc_control_hs;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // Control vector bit positions: {RegDst,Jump,Branch,MemRead,MemtoReg,
  // MemWrite,ALUSrc1,ALUSrc2,RegWrite,JALorJALR,PCWrite}
  localparam logic [10:0] B_REGDST = 11'h400;
  localparam logic [10:0] B_JUMP   = 11'h200;
  localparam logic [10:0] B_BRANCH = 11'h100;
  localparam logic [10:0] B_MEMRD  = 11'h080;
  localparam logic [10:0] B_M2R    = 11'h040;
  localparam logic [10:0] B_MEMWR  = 11'h020;
  localparam logic [10:0] B_SRC1   = 11'h010;
  localparam logic [10:0] B_SRC2   = 11'h008;
  localparam logic [10:0] B_REGWR  = 11'h004;
  localparam logic [10:0] B_JJ     = 11'h002;
  localparam logic [10:0] B_PCWR   = 11'h001;
  localparam logic [10:0] IFR      = B_MEMRD | B_PCWR;
  localparam logic [10:0] WB       = B_REGDST | B_REGWR;

  typedef struct {
    logic        rstn;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        rdy;
    logic [3:0]  st;
    logic [10:0] ctrl;
    logic [3:0]  be;
    logic [2:0]  cc;
    logic        halt;
    int unsigned ret;
  } vec_t;

  logic        CLK, RSTn, MEM_READY;
  logic [6:0]  opcode;
  logic [2:0]  funct3;

  logic        RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite;
  logic        ALUSrc1, ALUSrc2, RegWrite, JALorJALR, PCWrite, Halt;
  logic [6:0]  ALUOp;
  logic [3:0]  BE, state_o;
  logic [2:0]  Concat_control;
  logic [31:0] cycle_cnt, retire_cnt;

  logic        n_RegDst, n_Jump, n_Branch, n_MemRead, n_MemtoReg, n_MemWrite;
  logic        n_ALUSrc1, n_ALUSrc2, n_RegWrite, n_JALorJALR, n_PCWrite, n_Halt;
  logic [6:0]  n_ALUOp;
  logic [3:0]  n_BE, n_state_o;
  logic [2:0]  n_Concat_control;
  logic [3:0]  n_cycle_cnt, n_retire_cnt;

  logic [10:0] ctrl_act;
  assign ctrl_act = {RegDst, Jump, Branch, MemRead, MemtoReg, MemWrite,
                     ALUSrc1, ALUSrc2, RegWrite, JALorJALR, PCWrite};

  mc_control_hs #(.CNT_W(32), .MEM_HANDSHAKE(1'b1)) dut (
    .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .MEM_READY(MEM_READY),
    .RegDst(RegDst), .Jump(Jump), .Branch(Branch), .MemRead(MemRead),
    .MemtoReg(MemtoReg), .MemWrite(MemWrite), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .RegWrite(RegWrite), .JALorJALR(JALorJALR), .PCWrite(PCWrite), .ALUOp(ALUOp),
    .BE(BE), .Concat_control(Concat_control), .Halt(Halt), .state_o(state_o),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
  );

  mc_control_hs #(.CNT_W(4), .MEM_HANDSHAKE(1'b0)) dut_nh (
    .CLK(CLK), .RSTn(RSTn), .opcode(opcode), .funct3(funct3), .MEM_READY(MEM_READY),
    .RegDst(n_RegDst), .Jump(n_Jump), .Branch(n_Branch), .MemRead(n_MemRead),
    .MemtoReg(n_MemtoReg), .MemWrite(n_MemWrite), .ALUSrc1(n_ALUSrc1),
    .ALUSrc2(n_ALUSrc2), .RegWrite(n_RegWrite), .JALorJALR(n_JALorJALR),
    .PCWrite(n_PCWrite), .ALUOp(n_ALUOp), .BE(n_BE),
    .Concat_control(n_Concat_control), .Halt(n_Halt), .state_o(n_state_o),
    .cycle_cnt(n_cycle_cnt), .retire_cnt(n_retire_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs just after a falling edge, then settle before sampling.
  task automatic tick(input logic r, input logic [6:0] op, input logic [2:0] f,
                      input logic rd);
    @(negedge CLK);
    RSTn = r; opcode = op; funct3 = f; MEM_READY = rd;
    #1;
  endtask

  task automatic add(input logic r, input logic [6:0] op, input logic [2:0] f,
                     input logic rd, input logic [3:0] st, input logic [10:0] ctrl,
                     input logic [3:0] be, input logic [2:0] cc, input logic halt,
                     input int unsigned ret);
    vec_t v;
    v.rstn = r; v.op = op; v.f3 = f; v.rdy = rd; v.st = st; v.ctrl = ctrl;
    v.be = be; v.cc = cc; v.halt = halt; v.ret = ret;
    tbl.push_back(v);
  endtask

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic [3:0] st;
  } dec_t;

  initial begin
    int unsigned exp_cyc;
    int          mw_cnt;
    logic [3:0]  mw_be;
    logic [3:0]  nh_st [6];
    dec_t        dec [10];

    RSTn = 1'b0; opcode = OP_R; funct3 = 3'b000; MEM_READY = 1'b1;

    // Reset for two cycles; write strobes are forced low while RSTn=0
    tick(1'b0, OP_R, 3'b000, 1'b1);
    tick(1'b0, OP_R, 3'b000, 1'b1);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_memread", 32'(MemRead), 32'd1);
    chk("rst_pcwrite_forced", 32'(PCWrite), 32'd0);
    chk("rst_cycle", cycle_cnt, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);

    // R-type with MEM_READY low outside IF (must be ignored)
    add(1, OP_R, 0, 1,  0, IFR, 0, 0, 0, 0);
    add(1, OP_R, 0, 0,  1, 0,   0, 0, 0, 0);
    add(1, OP_R, 0, 0,  6, 0,   0, 0, 0, 0);
    add(1, OP_R, 0, 0,  7, WB,  0, 0, 0, 0);
    // Halfword load with two wait states in MEMRD
    add(1, OP_LOAD, 1, 1, 0, IFR, 0, 0, 0, 1);
    add(1, OP_LOAD, 1, 1, 1, 0, 0, 0, 0, 1);
    add(1, OP_LOAD, 1, 1, 2, B_SRC2, 0, 3'b011, 0, 1);
    add(1, OP_LOAD, 1, 0, 3, B_MEMRD, 4'b0011, 0, 0, 1);
    add(1, OP_LOAD, 1, 0, 3, B_MEMRD, 4'b0011, 0, 0, 1);
    add(1, OP_LOAD, 1, 1, 3, B_MEMRD, 4'b0011, 0, 0, 1);
    add(1, OP_LOAD, 1, 1, 4, WB | B_M2R, 0, 0, 0, 1);
    // Word store with a wait state in IF and in MEMWR
    add(1, OP_STORE, 2, 0, 0, B_MEMRD, 0, 0, 0, 2);
    add(1, OP_STORE, 2, 1, 0, IFR, 0, 0, 0, 2);
    add(1, OP_STORE, 2, 1, 1, 0, 0, 0, 0, 2);
    add(1, OP_STORE, 2, 1, 2, B_SRC2, 0, 3'b101, 0, 2);
    add(1, OP_STORE, 2, 0, 5, B_MEMWR, 4'b1111, 0, 0, 2);
    add(1, OP_STORE, 2, 1, 5, B_MEMWR, 4'b1111, 0, 0, 2);
    // I-type shift (funct3=101) selects the shift-immediate format
    add(1, OP_I, 5, 1, 0,  IFR, 0, 0, 0, 3);
    add(1, OP_I, 5, 1, 1,  0, 0, 0, 0, 3);
    add(1, OP_I, 5, 1, 12, B_SRC2, 0, 3'b110, 0, 3);
    add(1, OP_I, 5, 1, 7,  WB, 0, 0, 0, 3);
    // LUI, AUIPC, JAL, BEQ, JALR back to back
    add(1, OP_LUI, 0, 1, 0,  IFR, 0, 0, 0, 4);
    add(1, OP_LUI, 0, 1, 1,  0, 0, 0, 0, 4);
    add(1, OP_LUI, 0, 1, 13, B_SRC1 | B_SRC2, 0, 3'b001, 0, 4);
    add(1, OP_LUI, 0, 1, 14, WB, 0, 0, 0, 4);
    add(1, OP_AUIPC, 0, 1, 0,  IFR, 0, 0, 0, 5);
    add(1, OP_AUIPC, 0, 1, 1,  0, 0, 0, 0, 5);
    add(1, OP_AUIPC, 0, 1, 13, B_SRC1 | B_SRC2, 0, 3'b001, 0, 5);
    add(1, OP_AUIPC, 0, 1, 14, WB, 0, 0, 0, 5);
    add(1, OP_JAL, 0, 1, 0,  IFR, 0, 0, 0, 6);
    add(1, OP_JAL, 0, 1, 1,  0, 0, 0, 0, 6);
    add(1, OP_JAL, 0, 1, 9,  B_SRC1 | B_SRC2 | B_JUMP, 0, 3'b010, 0, 6);
    add(1, OP_JAL, 0, 1, 11, B_JUMP | WB, 0, 0, 0, 6);
    add(1, OP_BR, 0, 1, 0, IFR, 0, 0, 0, 7);
    add(1, OP_BR, 0, 1, 1, 0, 0, 0, 0, 7);
    add(1, OP_BR, 0, 1, 8, B_BRANCH, 0, 3'b100, 0, 7);
    add(1, OP_JALR, 0, 1, 0,  IFR, 0, 0, 0, 8);
    add(1, OP_JALR, 0, 1, 1,  0, 0, 0, 0, 8);
    add(1, OP_JALR, 0, 1, 10, B_SRC2 | B_JUMP | B_JJ, 0, 3'b011, 0, 8);
    add(1, OP_JALR, 0, 1, 11, B_JUMP | WB | B_JJ, 0, 0, 0, 8);
    // Store aborted by reset in MEMWR: no write, no retire, counters cleared
    add(1, OP_STORE, 2, 1, 0, IFR, 0, 0, 0, 9);
    add(1, OP_STORE, 2, 1, 1, 0, 0, 0, 0, 9);
    add(1, OP_STORE, 2, 1, 2, B_SRC2, 0, 3'b101, 0, 9);
    add(0, OP_STORE, 2, 1, 5, 0, 4'b1111, 0, 0, 9);
    add(1, OP_STORE, 2, 1, 0, IFR, 0, 0, 0, 0);

    exp_cyc = 0;
    foreach (tbl[i]) begin
      tick(tbl[i].rstn, tbl[i].op, tbl[i].f3, tbl[i].rdy);
      chk($sformatf("v%0d_state", i), 32'(state_o), 32'(tbl[i].st));
      chk($sformatf("v%0d_ctrl", i), 32'(ctrl_act), 32'(tbl[i].ctrl));
      chk($sformatf("v%0d_be", i), 32'(BE), 32'(tbl[i].be));
      chk($sformatf("v%0d_concat", i), 32'(Concat_control), 32'(tbl[i].cc));
      chk($sformatf("v%0d_halt", i), 32'(Halt), 32'(tbl[i].halt));
      chk($sformatf("v%0d_aluop", i), 32'(ALUOp), 32'(tbl[i].op));
      chk($sformatf("v%0d_retire", i), retire_cnt, tbl[i].ret);
      chk($sformatf("v%0d_cycle", i), cycle_cnt, exp_cyc);
      exp_cyc = tbl[i].rstn ? exp_cyc + 1 : 0;
    end

    // Decode boundaries: illegal encodings trap, neighbouring legal ones do not
    dec[0] = '{7'b0000000, 3'b000, 4'd15};
    dec[1] = '{OP_LOAD,    3'b011, 4'd15};
    dec[2] = '{OP_LOAD,    3'b110, 4'd15};
    dec[3] = '{OP_LOAD,    3'b100, 4'd2};
    dec[4] = '{OP_STORE,   3'b011, 4'd15};
    dec[5] = '{OP_STORE,   3'b010, 4'd2};
    dec[6] = '{OP_BR,      3'b010, 4'd15};
    dec[7] = '{OP_BR,      3'b001, 4'd8};
    dec[8] = '{OP_I,       3'b000, 4'd12};
    dec[9] = '{OP_JALR,    3'b001, 4'd15};
    foreach (dec[k]) begin
      tick(1'b0, dec[k].op, dec[k].f3, 1'b1);
      tick(1'b1, dec[k].op, dec[k].f3, 1'b1);
      tick(1'b1, dec[k].op, dec[k].f3, 1'b1);
      tick(1'b1, dec[k].op, dec[k].f3, 1'b1);
      chk($sformatf("dec%0d_state", k), 32'(state_o), 32'(dec[k].st));
      chk($sformatf("dec%0d_halt", k), 32'(Halt), 32'(dec[k].st == 4'd15));
    end

    // TRAP from the illegal JALR above is sticky; cycle_cnt keeps running
    for (int c = 0; c < 12; c++) begin
      tick(1'b1, OP_JALR, 3'b001, 1'b1);
      chk($sformatf("trap%0d_state", c), 32'(state_o), 32'd15);
      chk($sformatf("trap%0d_halt", c), 32'(Halt), 32'd1);
      chk($sformatf("trap%0d_ctrl", c), 32'(ctrl_act), 32'd0);
      chk($sformatf("trap%0d_retire", c), retire_cnt, 32'd0);
    end
    chk("trap_cycle", cycle_cnt, 32'd14);

    // No-handshake byte store with MEM_READY low throughout
    nh_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1};
    mw_cnt = 0;
    mw_be  = 4'b0000;
    tick(1'b0, OP_STORE, 3'b000, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, OP_STORE, 3'b000, 1'b0);
      chk($sformatf("nh%0d_state", c), 32'(n_state_o), 32'(nh_st[c]));
      if (n_MemWrite) begin
        mw_cnt++;
        mw_be = n_BE;
      end
      if (c == 0) begin
        chk("nh_if_pcwrite", 32'(n_PCWrite), 32'd1);
        chk("hs_if_pcwrite", 32'(PCWrite), 32'd0);
      end
    end
    chk("nh_memwrite_cycles", 32'(mw_cnt), 32'd1);
    chk("nh_store_be", 32'(mw_be), 32'b0001);
    chk("nh_retire", 32'(n_retire_cnt), 32'd1);
    chk("hs_stalled_state", 32'(state_o), 32'd0);
    chk("hs_stalled_retire", retire_cnt, 32'd0);

    // 16 R-type instructions in 64 cycles: 4-bit counters wrap together
    tick(1'b0, OP_R, 3'b000, 1'b1);
    for (int c = 0; c < 65; c++) tick(1'b1, OP_R, 3'b000, 1'b1);
    chk("wrap_cycle32", cycle_cnt, 32'd64);
    chk("wrap_retire32", retire_cnt, 32'd16);
    chk("wrap_cycle4", 32'(n_cycle_cnt), 32'd0);
    chk("wrap_retire4", 32'(n_retire_cnt), 32'd0);
    chk("wrap_state", 32'(state_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
